// File: rtl/apb_completer_mr.sv
`default_nettype none
// ============================================================================
// Module  : apb_completer_mr
// Brief   : APB4 completer decoding one port into NREGIONS register back-ends
//           with per-region security, stall-timeout watchdog and strobes.
// Revision: 1.0
// ============================================================================
module apb_completer_mr #(
    parameter int                             ADDR_WIDTH     = 32,
    parameter int                             DATA_WIDTH     = 32,
    parameter int                             NREGIONS       = 2,
    parameter logic [NREGIONS*ADDR_WIDTH-1:0] REGION_BASE    = {32'h8000_1000, 32'h8000_0000},
    parameter logic [NREGIONS*32-1:0]         REGION_NWORDS  = {32'd16, 32'd4},
    parameter logic [NREGIONS-1:0]            SECURE_ONLY    = '0,
    parameter int                             TIMEOUT_CYCLES = 16,
    localparam int                            STRB_W         = DATA_WIDTH / 8
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [STRB_W-1:0]              PSTRB,
    input  logic [2:0]                     PPROT,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NREGIONS-1:0]            wen,
    output logic [NREGIONS-1:0]            ren,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [STRB_W-1:0]              strobe,
    output logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NREGIONS*DATA_WIDTH-1:0] rdata,
    input  logic [NREGIONS-1:0]            request_stall,
    input  logic [NREGIONS-1:0]            error
);

    localparam int c_AL   = $clog2(STRB_W);
    localparam int c_SELW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
    localparam int c_CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic            c_TO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_ERROR  = 2'd2;

    logic [1:0]            r_state;
    logic [c_SELW-1:0]     r_sel;
    logic [c_CW-1:0]       r_cnt;
    logic [NREGIONS-1:0]   r_wen;
    logic [NREGIONS-1:0]   r_ren;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [STRB_W-1:0]     r_strobe;

    logic [NREGIONS-1:0]   w_in_range;
    logic                  w_hit;
    logic [c_SELW-1:0]     w_hit_idx;
    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_secure;
    logic                  w_misalign;
    logic                  w_req_err;
    logic                  w_setup;
    logic [NREGIONS-1:0]   w_onehot;
    logic                  w_stall;
    logic                  w_timeout;
    logic                  w_access_ready;
    wire                   w_unused_prot = &{1'b0, PPROT[2], PPROT[0]};

    // Range checks use one extra bit so a region ending at the top of the
    // address space cannot wrap around to zero.
    for (genvar gr = 0; gr < NREGIONS; gr++) begin : g_region
        localparam logic [ADDR_WIDTH:0] c_LO = {1'b0, REGION_BASE[gr*ADDR_WIDTH +: ADDR_WIDTH]};
        localparam logic [ADDR_WIDTH:0] c_HI =
            c_LO + (ADDR_WIDTH+1)'(REGION_NWORDS[gr*32 +: 32] * STRB_W);
        assign w_in_range[gr] = ({1'b0, PADDR} >= c_LO) && ({1'b0, PADDR} < c_HI);
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_base    = '0;
        w_secure  = 1'b0;
        // Descending scan so the lowest-numbered matching region wins.
        for (int r = NREGIONS - 1; r >= 0; r--) begin
            if (w_in_range[r]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_SELW'(r);
                w_base    = REGION_BASE[r*ADDR_WIDTH +: ADDR_WIDTH];
                w_secure  = SECURE_ONLY[r];
            end
        end
    end

    assign w_misalign = |PADDR[c_AL-1:0];
    assign w_req_err  = !w_hit | w_misalign | (w_secure & PPROT[1]);
    assign w_setup    = PSEL & !PENABLE;
    assign w_onehot   = NREGIONS'(1) << w_hit_idx;

    assign w_stall        = request_stall[r_sel];
    assign w_timeout      = c_TO_EN & w_stall & (r_cnt == c_TO_LAST);
    assign w_access_ready = !w_stall | w_timeout;

    always_comb begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        case (r_state)
            c_ACCESS: begin
                PREADY  = w_access_ready;
                PSLVERR = w_access_ready & (error[r_sel] | w_timeout);
                PRDATA  = rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
            end
            c_ERROR:  PSLVERR = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= c_IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_wen    <= '0;
            r_ren    <= '0;
            r_addr   <= '0;
            r_strobe <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_setup && w_req_err) begin
                        r_state <= c_ERROR;
                    end else if (w_setup) begin
                        r_state  <= c_ACCESS;
                        r_sel    <= w_hit_idx;
                        r_wen    <= PWRITE ? w_onehot : '0;
                        r_ren    <= PWRITE ? '0 : w_onehot;
                        r_addr   <= PADDR - w_base;
                        r_strobe <= PWRITE ? PSTRB : '0;
                        r_cnt    <= '0;
                    end
                end
                c_ACCESS: begin
                    if (w_access_ready) begin
                        r_state  <= c_IDLE;
                        r_wen    <= '0;
                        r_ren    <= '0;
                        r_strobe <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign wen    = r_wen;
    assign ren    = r_ren;
    assign addr   = r_addr;
    assign strobe = r_strobe;
    assign wdata  = PWDATA;

endmodule
`default_nettype wire

// File: tb/tb_apb_completer_mr.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_completer_mr
// Brief   : Directed vector bench for apb_completer_mr (32-bit, plus 64-bit
//           instance for alignment decode).
// Revision: 1.0
// ============================================================================
module tb_apb_completer_mr;

    logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  wen, ren, request_stall, error;
    logic [31:0] addr, wdata;
    logic [3:0]  strobe;
    logic [63:0] rdata;

    logic [63:0]  PRDATA64, wdata64;
    logic         PREADY64, PSLVERR64;
    logic [1:0]   wen64, ren64;
    logic [31:0]  addr64;
    logic [7:0]   strobe64;
    logic [127:0] rdata64;

    int errors = 0;
    int checks = 0;

    apb_completer_mr #(.SECURE_ONLY(2'b10)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .wen(wen), .ren(ren), .addr(addr), .strobe(strobe), .wdata(wdata),
        .rdata(rdata), .request_stall(request_stall), .error(error)
    );

    apb_completer_mr #(.DATA_WIDTH(64)) dut64 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA({32'h0, PWDATA}),
        .PSTRB({4'h0, PSTRB}), .PPROT(PPROT), .PRDATA(PRDATA64),
        .PREADY(PREADY64), .PSLVERR(PSLVERR64), .wen(wen64), .ren(ren64),
        .addr(addr64), .strobe(strobe64), .wdata(wdata64), .rdata(rdata64),
        .request_stall(2'b00), .error(2'b00)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [2:0]  prot;
        logic [1:0]  err;
        logic        exp_slverr;
        logic [1:0]  exp_wen;
        logic [1:0]  exp_ren;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strobe;
        logic [31:0] exp_prdata;
        logic        chk_addr;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] prot);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        PSTRB   = st;
        PPROT   = prot;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle wen"},     64'(wen),     64'h0);
        check({tag, " idle ren"},     64'(ren),     64'h0);
        check({tag, " idle PREADY"},  64'(PREADY),  64'h1);
        check({tag, " idle PSLVERR"}, 64'(PSLVERR), 64'h0);
        check({tag, " idle PRDATA"},  64'(PRDATA),  64'h0);
    endtask

    initial begin
        // Region 0: 0x8000_0000..0x8000_000F; region 1 (secure-only): 0x8000_1000..0x8000_103F.
        vt[0]  = '{1'b1, 32'h8000_1008, 32'hDEAD_BEEF, 4'b0110, 3'b000, 2'b00, 1'b0, 2'b10, 2'b00, 32'h8,  4'b0110, 32'hCAFE_F00D, 1'b1};
        vt[1]  = '{1'b0, 32'h8000_000C, 32'h0,         4'b1111, 3'b000, 2'b10, 1'b0, 2'b00, 2'b01, 32'hC,  4'b0000, 32'h1234_5678, 1'b1};
        vt[2]  = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,  4'b0000, 32'h0,         1'b0};
        vt[3]  = '{1'b1, 32'h8000_0002, 32'h1111_2222, 4'b1111, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,  4'b0000, 32'h0,         1'b0};
        vt[4]  = '{1'b1, 32'h8000_1000, 32'h3333_4444, 4'b1111, 3'b010, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,  4'b0000, 32'h0,         1'b0};
        vt[5]  = '{1'b0, 32'h8000_103C, 32'h0,         4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b10, 32'h3C, 4'b0000, 32'hCAFE_F00D, 1'b1};
        vt[6]  = '{1'b0, 32'h8000_1040, 32'h0,         4'b0000, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,  4'b0000, 32'h0,         1'b0};
        vt[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,  4'b0000, 32'h0,         1'b0};
        vt[8]  = '{1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'b1111, 3'b010, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0,  4'b1111, 32'h1234_5678, 1'b1};
        vt[9]  = '{1'b1, 32'h8000_0008, 32'h0000_0001, 4'b0001, 3'b000, 2'b01, 1'b1, 2'b01, 2'b00, 32'h8,  4'b0001, 32'h1234_5678, 1'b1};
        vt[10] = '{1'b0, 32'h8000_1010, 32'h0,         4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b10, 32'h10, 4'b0000, 32'hCAFE_F00D, 1'b1};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        request_stall = '0; error = '0;
        rdata   = {32'hCAFE_F00D, 32'h1234_5678};
        rdata64 = '0;

        repeat (2) @(negedge PCLK);
        #1;
        check("reset PREADY", 64'(PREADY), 64'h1);
        check("reset PSLVERR", 64'(PSLVERR), 64'h0);
        check("reset PRDATA", 64'(PRDATA), 64'h0);
        check("reset wen", 64'(wen), 64'h0);
        check("reset ren", 64'(ren), 64'h0);
        check("reset addr", 64'(addr), 64'h0);
        check("reset strobe", 64'(strobe), 64'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Back-to-back table: each setup follows the previous completion directly.
        for (int i = 0; i < 11; i++) begin
            error = vt[i].err;
            setup(vt[i].wr, vt[i].a, vt[i].wd, vt[i].st, vt[i].prot);
            check($sformatf("v%0d PREADY", i),  64'(PREADY),  64'h1);
            check($sformatf("v%0d PSLVERR", i), 64'(PSLVERR), 64'(vt[i].exp_slverr));
            check($sformatf("v%0d wen", i),     64'(wen),     64'(vt[i].exp_wen));
            check($sformatf("v%0d ren", i),     64'(ren),     64'(vt[i].exp_ren));
            check($sformatf("v%0d strobe", i),  64'(strobe),  64'(vt[i].exp_strobe));
            check($sformatf("v%0d PRDATA", i),  64'(PRDATA),  64'(vt[i].exp_prdata));
            check($sformatf("v%0d wdata", i),   64'(wdata),   64'(vt[i].wd));
            if (vt[i].chk_addr)
                check($sformatf("v%0d addr", i), 64'(addr), 64'(vt[i].exp_addr));
            @(negedge PCLK);
            #1;
            check_idle($sformatf("v%0d", i));
        end
        PSEL = 1'b0; error = '0;
        @(negedge PCLK);

        // Stalled read: region 0 busy for three access cycles.
        request_stall = 2'b01;
        setup(1'b0, 32'h8000_0004, 32'h0, 4'b0000, 3'b000);
        check("stall64 misalign PSLVERR", 64'(PSLVERR64), 64'h1);
        check("stall64 misalign PREADY", 64'(PREADY64), 64'h1);
        check("stall c1 PREADY", 64'(PREADY), 64'h0);
        check("stall c1 ren", 64'(ren), 64'h1);
        for (int k = 2; k <= 3; k++) begin
            @(negedge PCLK);
            #1;
            check($sformatf("stall c%0d PREADY", k), 64'(PREADY), 64'h0);
            check($sformatf("stall c%0d ren", k), 64'(ren), 64'h1);
        end
        @(negedge PCLK);
        request_stall = 2'b00;
        #1;
        check("stall c4 PREADY", 64'(PREADY), 64'h1);
        check("stall c4 ren", 64'(ren), 64'h1);
        check("stall c4 PRDATA", 64'(PRDATA), 64'h1234_5678);
        check("stall c4 PSLVERR", 64'(PSLVERR), 64'h0);
        @(negedge PCLK);
        #1;
        check_idle("stall");
        PSEL = 1'b0;
        @(negedge PCLK);

        // Timeout: region 1 never ready, forced error on the 16th access cycle.
        request_stall = 2'b10;
        setup(1'b0, 32'h8000_1004, 32'h0, 4'b0000, 3'b000);
        check("to c1 PREADY", 64'(PREADY), 64'h0);
        for (int k = 2; k <= 15; k++) begin
            @(negedge PCLK);
            #1;
            check($sformatf("to c%0d PREADY", k), 64'(PREADY), 64'h0);
        end
        @(negedge PCLK);
        #1;
        check("to c16 PREADY", 64'(PREADY), 64'h1);
        check("to c16 PSLVERR", 64'(PSLVERR), 64'h1);
        check("to c16 ren", 64'(ren), 64'h2);
        @(negedge PCLK);
        #1;
        check_idle("to");
        // Region 1 still stalls, but region 0 is selected now.
        setup(1'b0, 32'h8000_0008, 32'h0, 4'b0000, 3'b000);
        check("post-to PREADY", 64'(PREADY), 64'h1);
        check("post-to PSLVERR", 64'(PSLVERR), 64'h0);
        check("post-to PRDATA", 64'(PRDATA), 64'h1234_5678);
        check("post-to ren", 64'(ren), 64'h1);
        @(negedge PCLK);
        PSEL = 1'b0;
        request_stall = 2'b00;
        @(negedge PCLK);

        // Asynchronous reset during a stalled write.
        request_stall = 2'b01;
        setup(1'b1, 32'h8000_0004, 32'hFFFF_0000, 4'b1111, 3'b000);
        check("rst pre wen", 64'(wen), 64'h1);
        check("rst pre addr", 64'(addr), 64'h4);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst mid wen", 64'(wen), 64'h0);
        check("rst mid ren", 64'(ren), 64'h0);
        check("rst mid strobe", 64'(strobe), 64'h0);
        check("rst mid addr", 64'(addr), 64'h0);
        check("rst mid PREADY", 64'(PREADY), 64'h1);
        check("rst mid PSLVERR", 64'(PSLVERR), 64'h0);
        check("rst mid PRDATA", 64'(PRDATA), 64'h0);
        @(negedge PCLK);
        PSEL = 1'b0;
        request_stall = 2'b00;
        PRESETn = 1'b1;
        @(negedge PCLK);

        setup(1'b0, 32'h8000_000C, 32'h0, 4'b0000, 3'b000);
        check("recover PREADY", 64'(PREADY), 64'h1);
        check("recover ren", 64'(ren), 64'h1);
        check("recover PRDATA", 64'(PRDATA), 64'h1234_5678);
        @(negedge PCLK);
        PSEL = 1'b0;
        #1;
        check_idle("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
